// File: rtl/fc_irq_pkg.sv
// Shared types and helpers for the fabric-controller interrupt bridge.
package fc_irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK_WAIT
    } irq_state_e;

    localparam int unsigned MaxIrq = 64;

    // Fixed-priority encoder; high_first picks the highest set index, else the lowest.
    function automatic int unsigned prio_enc(input logic [MaxIrq-1:0] vec, input bit high_first);
        int unsigned idx;
        idx = 0;
        if (high_first) begin
            for (int i = 0; i < MaxIrq; i++) begin
                if (vec[i]) idx = i;
            end
        end else begin
            for (int i = MaxIrq - 1; i >= 0; i--) begin
                if (vec[i]) idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fc_irq_bridge_if.sv
// Core-side request/acknowledge bundle: ID-style request plus one-hot line vector.
interface fc_irq_bridge_if #(
    parameter int unsigned NB_IRQ       = 32,
    parameter int unsigned IRQ_ID_WIDTH = $clog2(NB_IRQ)
);
    logic                    irq_req;
    logic [IRQ_ID_WIDTH-1:0] irq_id;
    logic [NB_IRQ-1:0]       irq_x;
    logic                    irq_ack;
    logic [IRQ_ID_WIDTH-1:0] irq_ack_id;

    modport master (
        output irq_req,
        output irq_id,
        output irq_x,
        input  irq_ack,
        input  irq_ack_id
    );

    modport slave (
        input  irq_req,
        input  irq_id,
        input  irq_x,
        output irq_ack,
        output irq_ack_id
    );
endinterface

// File: rtl/fc_irq_fifo.sv
// Synchronous event FIFO with occupancy count; push while full and pop while empty are dropped.
module fc_irq_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic                       fulln_o,
    output logic                       valid_o,
    output logic [Width-1:0]           head_o,
    output logic [$clog2(Depth):0]     count_o
);
    localparam int unsigned AW   = $clog2(Depth);
    localparam int unsigned CntW = AW + 1;

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             full, empty, push_ok, pop_ok;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign push_ok = push_i & ~full;
    assign pop_ok  = pop_i & ~empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wptr_q] <= data_i;
    end

    assign fulln_o = ~full;
    assign valid_o = ~empty;
    assign head_o  = empty ? '0 : mem[rptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/fc_irq_bridge.sv
// Edge capture, pending/mask, fixed-priority arbitration and the core request/ack FSM.
module fc_irq_bridge
    import fc_irq_pkg::*;
#(
    parameter int unsigned NB_IRQ          = 32,
    parameter int unsigned IRQ_ID_WIDTH    = $clog2(NB_IRQ),
    parameter int unsigned EVENT_ID_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned FIFO_IRQ_LINE   = 26,
    parameter bit          PRIO_HIGH_FIRST = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NB_IRQ-1:0]         irq_i,
    input  logic [NB_IRQ-1:0]         irq_mask_i,
    input  logic                      event_fifo_valid_i,
    input  logic [EVENT_ID_WIDTH-1:0] event_fifo_data_i,
    output logic                      event_fifo_fulln_o,
    output logic [EVENT_ID_WIDTH-1:0] event_id_o,
    output logic                      event_valid_o,
    input  logic                      event_pop_i,
    output logic [NB_IRQ-1:0]         pending_o,
    fc_irq_bridge_if.master           core
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [NB_IRQ-1:0] One = {{(NB_IRQ - 1){1'b0}}, 1'b1};

    irq_state_e              state_q, state_d;
    logic [IRQ_ID_WIDTH-1:0] id_q, id_d, winner;
    logic                    req_q, req_d;
    logic [NB_IRQ-1:0]       x_q, x_d;
    logic [NB_IRQ-1:0]       irq_q, pending_q, pending_d, set_vec, clr_vec, eligible;
    logic [CntW-1:0]         fifo_count, count_next;
    logic                    push_ok, pop_ok, fifo_set, any_elig, ack_ok;

    fc_irq_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EVENT_ID_WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (event_fifo_valid_i),
        .data_i  (event_fifo_data_i),
        .pop_i   (event_pop_i),
        .fulln_o (event_fifo_fulln_o),
        .valid_o (event_valid_o),
        .head_o  (event_id_o),
        .count_o (fifo_count)
    );

    assign push_ok    = event_fifo_valid_i & event_fifo_fulln_o;
    assign pop_ok     = event_pop_i & event_valid_o;
    assign count_next = fifo_count + CntW'(push_ok) - CntW'(pop_ok);
    // The FIFO line re-arms whenever a new entry becomes (or stays) the head.
    assign fifo_set   = (push_ok && fifo_count == '0) || (pop_ok && count_next != '0);

    assign eligible = pending_q & irq_mask_i;
    assign any_elig = |eligible;
    assign winner   = IRQ_ID_WIDTH'(prio_enc(MaxIrq'(eligible), PRIO_HIGH_FIRST));
    assign ack_ok   = (state_q == REQ) && core.irq_ack;

    always_comb begin
        set_vec                = irq_i & ~irq_q;
        set_vec[FIFO_IRQ_LINE] = fifo_set;
        clr_vec                = ack_ok ? (One << core.irq_ack_id) : '0;
        pending_d              = (pending_q & ~clr_vec) | set_vec;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    id_d    = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (core.irq_ack) begin
                    state_d = ACK_WAIT;
                end else if (!any_elig) begin
                    state_d = IDLE;
                end else if (winner != id_q) begin
                    id_d = winner;
                end
            end
            ACK_WAIT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        req_d = (state_d == REQ);
        x_d   = req_d ? (One << id_d) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            id_q      <= '0;
            req_q     <= 1'b0;
            x_q       <= '0;
            irq_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            req_q     <= req_d;
            x_q       <= x_d;
            irq_q     <= irq_i;
            pending_q <= pending_d;
        end
    end

    assign core.irq_req = req_q;
    assign core.irq_id  = id_q;
    assign core.irq_x   = x_q;
    assign pending_o    = pending_q;
endmodule

// File: tb/tb_fc_irq_bridge.sv
// Directed table-driven bench for fc_irq_bridge with default parameters.
module tb_fc_irq_bridge;
    localparam int unsigned NB = 32;
    localparam logic [31:0] M   = 32'hFFFF_FFFF;
    localparam logic [31:0] P26 = 32'h0400_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] irq, mask;
    logic        push, pop;
    logic [7:0]  data;
    logic        fulln, evalid;
    logic [7:0]  ehead;
    logic [31:0] pend;

    int n_chk = 0;
    int n_err = 0;

    fc_irq_bridge_if #(.NB_IRQ(NB)) core_if ();

    fc_irq_bridge dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .irq_i              (irq),
        .irq_mask_i         (mask),
        .event_fifo_valid_i (push),
        .event_fifo_data_i  (data),
        .event_fifo_fulln_o (fulln),
        .event_id_o         (ehead),
        .event_valid_o      (evalid),
        .event_pop_i        (pop),
        .pending_o          (pend),
        .core               (core_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] irq;
        logic [31:0] mask;
        logic        push;
        logic [7:0]  data;
        logic        pop;
        logic        ack;
        logic [4:0]  ack_id;
        logic        ereq;
        logic [4:0]  eid;
        logic [31:0] epend;
        logic        evalid;
        logic [7:0]  ehead;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [31:0] i, input logic [31:0] m, input logic pu,
                       input logic [7:0] d, input logic po, input logic a, input logic [4:0] aid,
                       input logic er, input logic [4:0] ei, input logic [31:0] ep,
                       input logic ev, input logic [7:0] eh);
        vec_t v;
        v.irq = i; v.mask = m; v.push = pu; v.data = d; v.pop = po; v.ack = a;
        v.ack_id = aid; v.ereq = er; v.eid = ei; v.epend = ep; v.evalid = ev; v.ehead = eh;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, 64'(core_if.irq_req), 64'd0);
        chk({tag, "_id"}, 64'(core_if.irq_id), 64'd0);
        chk({tag, "_x"}, 64'(core_if.irq_x), 64'd0);
        chk({tag, "_pend"}, 64'(pend), 64'd0);
        chk({tag, "_fulln"}, 64'(fulln), 64'd1);
        chk({tag, "_valid"}, 64'(evalid), 64'd0);
        chk({tag, "_head"}, 64'(ehead), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; irq = '0; mask = M; push = 1'b0; pop = 1'b0; data = '0;
        core_if.irq_ack = 1'b0; core_if.irq_ack_id = '0;
        repeat (2) step();
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        //   irq        mask        psh data  pop ack id   req id  pend        vld head
        add(32'h0,     M,          0,  8'h0, 0,  0,  5'd0,  0, 5'd0,  32'h0,      0, 8'h0);
        add(32'h8,     M,          0,  8'h0, 0,  0,  5'd0,  0, 5'd0,  32'h8,      0, 8'h0);
        add(32'h8,     M,          0,  8'h0, 0,  0,  5'd0,  1, 5'd3,  32'h8,      0, 8'h0);
        add(32'h408,   M,          0,  8'h0, 0,  0,  5'd0,  1, 5'd3,  32'h408,    0, 8'h0);
        add(32'h408,   M,          0,  8'h0, 0,  0,  5'd0,  1, 5'd10, 32'h408,    0, 8'h0);
        add(32'h408,   M,          0,  8'h0, 0,  1,  5'd10, 0, 5'd0,  32'h8,      0, 8'h0);
        add(32'h408,   M,          0,  8'h0, 0,  0,  5'd0,  0, 5'd0,  32'h8,      0, 8'h0);
        add(32'h408,   M,          0,  8'h0, 0,  0,  5'd0,  1, 5'd3,  32'h8,      0, 8'h0);
        add(32'h408,   M,          0,  8'h0, 0,  1,  5'd3,  0, 5'd0,  32'h0,      0, 8'h0);
        add(32'h408,   M,          0,  8'h0, 0,  0,  5'd0,  0, 5'd0,  32'h0,      0, 8'h0);
        add(32'h20,    M,          0,  8'h0, 0,  0,  5'd0,  0, 5'd0,  32'h20,     0, 8'h0);
        add(32'h20,    M,          0,  8'h0, 0,  0,  5'd0,  1, 5'd5,  32'h20,     0, 8'h0);
        add(32'h20,    ~32'h20,    0,  8'h0, 0,  0,  5'd0,  0, 5'd0,  32'h20,     0, 8'h0);
        add(32'h20,    M,          0,  8'h0, 0,  0,  5'd0,  1, 5'd5,  32'h20,     0, 8'h0);
        add(32'h20,    M,          0,  8'h0, 0,  1,  5'd5,  0, 5'd0,  32'h0,      0, 8'h0);
        add(32'h0,     M,          0,  8'h0, 0,  0,  5'd0,  0, 5'd0,  32'h0,      0, 8'h0);
        add(32'h0,     M,          1,  8'hA5, 0, 0,  5'd0,  0, 5'd0,  P26,        1, 8'hA5);
        add(32'h0,     M,          1,  8'h3C, 0, 0,  5'd0,  1, 5'd26, P26,        1, 8'hA5);
        add(32'h0,     M,          0,  8'h0, 0,  1,  5'd26, 0, 5'd0,  32'h0,      1, 8'hA5);
        add(32'h0,     M,          0,  8'h0, 1,  0,  5'd0,  0, 5'd0,  P26,        1, 8'h3C);
        add(32'h0,     M,          0,  8'h0, 0,  0,  5'd0,  1, 5'd26, P26,        1, 8'h3C);
        add(32'h0,     M,          0,  8'h0, 0,  1,  5'd26, 0, 5'd0,  32'h0,      1, 8'h3C);
        add(32'h0,     M,          0,  8'h0, 1,  0,  5'd0,  0, 5'd0,  32'h0,      0, 8'h0);
        add(32'h0,     M,          0,  8'h0, 0,  0,  5'd0,  0, 5'd0,  32'h0,      0, 8'h0);

        foreach (vq[i]) begin
            irq = vq[i].irq; mask = vq[i].mask; push = vq[i].push; data = vq[i].data;
            pop = vq[i].pop; core_if.irq_ack = vq[i].ack; core_if.irq_ack_id = vq[i].ack_id;
            step();
            chk($sformatf("v%0d_req", i), 64'(core_if.irq_req), 64'(vq[i].ereq));
            if (vq[i].ereq) chk($sformatf("v%0d_id", i), 64'(core_if.irq_id), 64'(vq[i].eid));
            chk($sformatf("v%0d_x", i), 64'(core_if.irq_x),
                vq[i].ereq ? (64'd1 << vq[i].eid) : 64'd0);
            chk($sformatf("v%0d_pend", i), 64'(pend), 64'(vq[i].epend));
            chk($sformatf("v%0d_valid", i), 64'(evalid), 64'(vq[i].evalid));
            if (vq[i].evalid) chk($sformatf("v%0d_head", i), 64'(ehead), 64'(vq[i].ehead));
            chk($sformatf("v%0d_fulln", i), 64'(fulln), 64'd1);
        end
        irq = '0; push = 1'b0; pop = 1'b0; core_if.irq_ack = 1'b0; core_if.irq_ack_id = '0;

        // Fill past capacity with requests masked off.
        mask = '0;
        for (int i = 0; i < 9; i++) begin
            push = 1'b1; data = 8'h10 + 8'(i);
            step();
            if (i == 6) chk("full_after7_fulln", 64'(fulln), 64'd1);
            if (i >= 7) chk($sformatf("full_after%0d_fulln", i + 1), 64'(fulln), 64'd0);
        end
        chk("full_head", 64'(ehead), 64'h10);
        push = 1'b1; data = 8'hEE; pop = 1'b1;
        step();
        chk("full_pushpop_fulln", 64'(fulln), 64'd1);
        chk("full_pushpop_head", 64'(ehead), 64'h11);
        push = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            step();
            if (j < 7) begin
                chk($sformatf("drain%0d_head", j), 64'(ehead), 64'h11 + 64'(j));
                chk($sformatf("drain%0d_valid", j), 64'(evalid), 64'd1);
            end else begin
                chk("drain7_valid", 64'(evalid), 64'd0);
            end
        end
        pop = 1'b0;
        chk("full_masked_req", 64'(core_if.irq_req), 64'd0);

        // Reset while requesting with three entries queued.
        mask = M;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; data = 8'h50 + 8'(i);
            step();
        end
        push = 1'b0;
        step();
        chk("prerst_req", 64'(core_if.irq_req), 64'd1);
        chk("prerst_id", 64'(core_if.irq_id), 64'd26);
        chk("prerst_head", 64'(ehead), 64'h50);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("postrst_valid", 64'(evalid), 64'd0);
        chk("postrst_fulln", 64'(fulln), 64'd1);
        chk("postrst_pend", 64'(pend), 64'd0);
        chk("postrst_req", 64'(core_if.irq_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fc_irq_bridge.md
# fc_irq_bridge

Parametrised interrupt bridge between fabric-controller interrupt sources and the FC core. It latches edge-triggered lines and an event FIFO into pending bits, applies a mask, and arbitrates by fixed priority. It drives both an ID-style request (RI5CY) and a one-hot line vector (Ibex `irq_x`) from one request/acknowledge state machine. It generalises the fixed 32-line, 5-bit-ID path to any line count and FIFO depth, and adds preemption and masked-request withdrawal.

## Interface
Parameters:
- `NB_IRQ`, 32: number of interrupt lines, 2..64.
- `IRQ_ID_WIDTH`, `$clog2(NB_IRQ)`: width of the interrupt ID.
- `EVENT_ID_WIDTH`, 8: width of an event FIFO entry.
- `FIFO_DEPTH`, 8: event FIFO entries; must be a power of 2, at least 2.
- `FIFO_IRQ_LINE`, 26: line index driven by the event FIFO; `irq_i` on this index is ignored.
- `PRIO_HIGH_FIRST`, 1: 1 means the highest index wins; 0 means the lowest index wins.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_i`, in, 1: clock.
  - `rst_ni`, in, 1: asynchronous active-low reset.
- Interrupt sources and mask:
  - `irq_i`, in, NB_IRQ: interrupt lines; a rising edge sets the pending bit.
  - `irq_mask_i`, in, NB_IRQ: 1 enables the line for requests.
- Event FIFO:
  - `event_fifo_valid_i`, in, 1: push strobe.
  - `event_fifo_data_i`, in, EVENT_ID_WIDTH: push data.
  - `event_fifo_fulln_o`, out, 1: 1 when the FIFO can accept a push.
  - `event_id_o`, out, EVENT_ID_WIDTH: FIFO head.
  - `event_valid_o`, out, 1: FIFO not empty.
  - `event_pop_i`, in, 1: software pop strobe.
- Core side:
  - `core_irq_req_o`, out, 1: interrupt request.
  - `core_irq_id_o`, out, IRQ_ID_WIDTH: requested ID.
  - `core_irq_x_o`, out, NB_IRQ: one-hot of the requested ID while a request is active, else 0.
  - `core_irq_ack_i`, in, 1: acknowledge strobe.
  - `core_irq_ack_id_i`, in, IRQ_ID_WIDTH: acknowledged ID.
- Status:
  - `pending_o`, out, NB_IRQ: raw pending bits.

## Operation
Edge capture and pending bits:
- `irq_q` holds the previous `irq_i`.
- `pending[k]` is set when `irq_i[k] & ~irq_q[k]`, for every k except `FIFO_IRQ_LINE`.

Event FIFO:
- A push is accepted when `event_fifo_valid_i & event_fifo_fulln_o`. A push while full is dropped silently.
- A pop occurs when `event_pop_i & event_valid_o`. A pop while empty is ignored.
- Simultaneous push and pop when full: the pop is taken and the push is dropped. Simultaneous push and pop when empty: the push is taken and the pop is ignored.
- `pending[FIFO_IRQ_LINE]` is set on a push into an empty FIFO, and on a pop that leaves the count above 0.

Pending update rules:
- Set has priority over clear on the same bit in the same cycle.
- The eligible vector is `pending & irq_mask_i`.
- The winner is the highest or lowest set index, per `PRIO_HIGH_FIRST`.

FSM states (package enum):
- IDLE:
  - If any line is eligible, latch the winner into `id_q` and go to REQ.
- REQ (`core_irq_req_o`=1):
  - On `core_irq_ack_i`, clear `pending[core_irq_ack_id_i]` and go to ACK_WAIT. The ack ID need not match `id_q`; the acked bit is cleared regardless.
  - Otherwise, if nothing is eligible (line masked or cleared), go to IDLE.
  - Otherwise, if the winner differs from `id_q`, update `id_q` and stay in REQ (preemption).
- ACK_WAIT: one cycle with the request deasserted, then IDLE.

Other rules:
- An ack outside REQ is ignored.
- Reset mid-operation returns immediately to IDLE and clears all pending bits, `irq_q` and the FIFO.

## Timing
- Reset values: `core_irq_req_o`=0, `core_irq_id_o`=0, `core_irq_x_o`=0, `pending_o`=0, `event_fifo_fulln_o`=1, `event_valid_o`=0, `event_id_o`=0.
- All core-side outputs are registered.
- A rising edge on `irq_i` in cycle t sets pending at t+1; the request is asserted at t+2.
- A push into an empty FIFO in cycle t sets `event_valid_o` and the pending bit at t+1.
- An ack in cycle a drops the request at a+1 and clears pending at a+1. The next request is asserted no earlier than a+3.
- Preemption: the ID changes one cycle after the higher-priority line becomes eligible. `core_irq_req_o` stays high throughout.
- `core_irq_x_o` always equals `onehot(core_irq_id_o) & {NB_IRQ{core_irq_req_o}}`.

## Structure
- `fc_irq_pkg` contains:
  - the `irq_state_e` enum {IDLE, REQ, ACK_WAIT};
  - a priority-encoder function parametrised on direction.
- Sub-module `fc_irq_fifo`: synchronous FIFO with count, full/empty flags and the head output.
- The edge detector, pending register, arbiter and FSM live in the top module.

## Test plan
- Rising edge on `irq_i[3]`, mask all ones → request with ID 3 at t+2 and `core_irq_x_o`=0x8; ack with ID 3 → request low at a+1, `pending_o`=0.
- Request active on ID 3, then edge on line 10 (`PRIO_HIGH_FIRST`=1) → ID becomes 10 one cycle later with the request still high; after ack 10, ID 3 is requested again at a+3.
- Pending on line 5 with mask bit 5 cleared during REQ → request drops next cycle; setting mask bit 5 again → request with ID 5.
- Push 0xA5 and 0x3C into an empty FIFO → request with ID 26 and `event_id_o`=0xA5. Ack 26, then pop → pending 26 is set again and `event_id_o`=0x3C. A second ack and pop → `event_valid_o`=0.
- Nine pushes with `FIFO_DEPTH`=8 → `event_fifo_fulln_o`=0 after the eighth and the ninth is dropped. Simultaneous push and pop when full → count 7, then fulln=1.
- Assert `rst_ni` low during REQ with the FIFO holding 3 entries → all outputs at reset values asynchronously and the FIFO empty after release.
